// File: rtl/eth_rx_pkg.sv
// -----------------------------------------------------------------------------
// eth_rx_pkg
// Shared definitions for the RGMII receive path: preamble/SFD byte values,
// the frame-delimiter FSM state type, default frame-length limits and a
// saturating counter helper used by the optional statistics counters.
// -----------------------------------------------------------------------------
package eth_rx_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Longest post-SFD byte count (destination MAC through FCS, VLAN tagged)
  localparam int MAX_FRAME_LEN_DEFAULT = 1522;
  localparam int LEN_W_DEFAULT         = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DISCARD  = 2'd3
  } rx_state_t;

  // 16-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rgmii_ddr_in.sv
// -----------------------------------------------------------------------------
// rgmii_ddr_in
// Double-data-rate input capture (behavioural altddio_in equivalent). Each bit
// is sampled on the rising and on the falling edge of clk; both halves are
// then re-registered on the next rising edge so they leave the block aligned.
// Data presented during clock cycle N appears on rise_data/fall_data in N+1.
//
// Ports:
//   clk        capture clock (RGMII RXC)
//   rst        synchronous active-high reset of the aligned outputs
//   ddr_in     WIDTH-bit DDR input bus
//   rise_data  value sampled on the rising edge of the previous cycle
//   fall_data  value sampled on the falling edge of the previous cycle
// -----------------------------------------------------------------------------
module rgmii_ddr_in #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ddr_in,
  output logic [WIDTH-1:0] rise_data,
  output logic [WIDTH-1:0] fall_data
);

  logic [WIDTH-1:0] rise_cap_r;
  logic [WIDTH-1:0] fall_cap_r;
  logic [WIDTH-1:0] rise_align_r;
  logic [WIDTH-1:0] fall_align_r;

  // Rising-edge sample of the DDR bus
  always_ff @(posedge clk) begin
    rise_cap_r <= ddr_in;
  end

  // Falling-edge sample of the DDR bus
  always_ff @(negedge clk) begin
    fall_cap_r <= ddr_in;
  end

  // Re-time both halves onto the rising edge so downstream sees one word
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_align_r <= {WIDTH{1'b0}};
      fall_align_r <= {WIDTH{1'b0}};
    end else begin
      rise_align_r <= rise_cap_r;
      fall_align_r <= fall_cap_r;
    end
  end

  assign rise_data = rise_align_r;
  assign fall_data = fall_align_r;

endmodule

// File: rtl/rgmii_rx_to_frame.sv
// -----------------------------------------------------------------------------
// rgmii_rx_to_frame
// RGMII receive front end: rebuilds the GMII byte stream from the DDR RGMII
// bus, strips preamble/SFD and delivers payload bytes (destination MAC through
// FCS) with sof/eof markers, an error flag and a byte count. Single clock
// domain (rgmii_rx_clk), synchronous active-high reset.
//
// Optional feature macro: RGMII_RX_STATS_EN adds saturating good/bad frame
// counters on stat_frames / stat_errors.
//
// Ports:
//   rgmii_rx_clk, rst           clock and synchronous reset
//   rgmii_rx_data, rgmii_rx_ctl RGMII RXD[3:0] and RX_CTL (DDR)
//   gmii_rx_data/dv/er          reconstructed GMII stream (latency 2)
//   frame_data/valid            payload byte stream, one byte per clock
//   frame_sof/eof               first/last payload byte markers
//   frame_err, frame_len        error flag and byte count on the eof beat
//   stat_frames, stat_errors    counters (only with RGMII_RX_STATS_EN)
// -----------------------------------------------------------------------------
module rgmii_rx_to_frame
  import eth_rx_pkg::*;
#(
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEFAULT,
  parameter int LEN_W         = LEN_W_DEFAULT
) (
  input  logic             rgmii_rx_clk,
  input  logic             rst,
  input  logic [3:0]       rgmii_rx_data,
  input  logic             rgmii_rx_ctl,
  output logic [7:0]       gmii_rx_data,
  output logic             gmii_rx_dv,
  output logic             gmii_rx_er,
  output logic [7:0]       frame_data,
  output logic             frame_valid,
  output logic             frame_sof,
  output logic             frame_eof,
  output logic             frame_err,
  output logic [LEN_W-1:0] frame_len
`ifdef RGMII_RX_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_errors
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_FRAME_LEN);
  localparam logic [LEN_W-1:0] ZERO_LEN = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] ONE_LEN  = {{(LEN_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // DDR capture and GMII reconstruction
  // ---------------------------------------------------------------------------
  logic [4:0] ddr_rise_s;
  logic [4:0] ddr_fall_s;

  rgmii_ddr_in #(
    .WIDTH (5)
  ) u_ddr_in (
    .clk       (rgmii_rx_clk),
    .rst       (rst),
    .ddr_in    ({rgmii_rx_ctl, rgmii_rx_data}),
    .rise_data (ddr_rise_s),
    .fall_data (ddr_fall_s)
  );

  logic [7:0] gmii_data_r;
  logic       gmii_dv_r;
  logic       gmii_er_r;

  // GMII stage: low nibble rides the rising edge; RX_CTL falling half is DV^ER
  always_ff @(posedge rgmii_rx_clk) begin
    if (rst) begin
      gmii_data_r <= 8'h00;
      gmii_dv_r   <= 1'b0;
      gmii_er_r   <= 1'b0;
    end else begin
      gmii_data_r <= {ddr_fall_s[3:0], ddr_rise_s[3:0]};
      gmii_dv_r   <= ddr_rise_s[4];
      gmii_er_r   <= ddr_rise_s[4] ^ ddr_fall_s[4];
    end
  end

  assign gmii_rx_data = gmii_data_r;
  assign gmii_rx_dv   = gmii_dv_r;
  assign gmii_rx_er   = gmii_er_r;

  // ---------------------------------------------------------------------------
  // Frame delimiter
  // count_r is the number of payload bytes loaded into hold_r so far; the byte
  // in hold_r is only emitted once we know whether it is the last one, which is
  // what lets eof ride on the final data beat.
  // ---------------------------------------------------------------------------
  rx_state_t        state_r, state_s;
  logic [7:0]       hold_r, hold_s;
  logic [LEN_W-1:0] count_r, count_s;
  logic             sticky_err_r, sticky_err_s;

  logic [7:0]       fdata_s;
  logic             fvalid_s;
  logic             fsof_s;
  logic             feof_s;
  logic             ferr_s;
  logic [LEN_W-1:0] flen_s;
  logic             discard_entry_s;

  // Next-state and output decode for the frame delimiter
  always_comb begin
    state_s         = state_r;
    hold_s          = hold_r;
    count_s         = count_r;
    sticky_err_s    = sticky_err_r;
    fdata_s         = 8'h00;
    fvalid_s        = 1'b0;
    fsof_s          = 1'b0;
    feof_s          = 1'b0;
    ferr_s          = 1'b0;
    flen_s          = ZERO_LEN;
    discard_entry_s = 1'b0;

    case (state_r)
      IDLE: begin
        count_s      = ZERO_LEN;
        sticky_err_s = 1'b0;
        // dv low (including false carrier with er high) keeps us idle
        if (gmii_dv_r) begin
          if (gmii_data_r == PREAMBLE_BYTE) begin
            state_s = PREAMBLE;
          end else if (gmii_data_r == SFD_BYTE) begin
            state_s = DATA;
          end else begin
            state_s         = DISCARD;
            discard_entry_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      PREAMBLE: begin
        if (gmii_dv_r) begin
          if (gmii_data_r == PREAMBLE_BYTE) begin
            state_s = PREAMBLE;
          end else if (gmii_data_r == SFD_BYTE) begin
            state_s = DATA;
          end else begin
            state_s         = DISCARD;
            discard_entry_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      DATA: begin
        if (gmii_dv_r) begin
          if (count_r == MAX_LEN) begin
            // Overrun: close the frame on the last byte that fits, drop the rest
            fvalid_s     = 1'b1;
            fdata_s      = hold_r;
            fsof_s       = (count_r == ONE_LEN);
            feof_s       = 1'b1;
            ferr_s       = 1'b1;
            flen_s       = count_r;
            state_s      = DISCARD;
            count_s      = ZERO_LEN;
            sticky_err_s = 1'b0;
          end else begin
            hold_s       = gmii_data_r;
            count_s      = count_r + ONE_LEN;
            sticky_err_s = sticky_err_r | gmii_er_r;
            if (count_r != ZERO_LEN) begin
              fvalid_s = 1'b1;
              fdata_s  = hold_r;
              fsof_s   = (count_r == ONE_LEN);
            end else begin
              fvalid_s = 1'b0;
            end
          end
        end else begin
          // Carrier dropped: the held byte is the last one (none if SFD only)
          if (count_r != ZERO_LEN) begin
            fvalid_s = 1'b1;
            fdata_s  = hold_r;
            fsof_s   = (count_r == ONE_LEN);
            feof_s   = 1'b1;
            ferr_s   = sticky_err_r;
            flen_s   = count_r;
          end else begin
            fvalid_s = 1'b0;
          end
          state_s      = IDLE;
          count_s      = ZERO_LEN;
          sticky_err_s = 1'b0;
        end
      end

      DISCARD: begin
        if (gmii_dv_r) begin
          state_s = DISCARD;
        end else begin
          state_s = IDLE;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  logic [7:0]       frame_data_r;
  logic             frame_valid_r;
  logic             frame_sof_r;
  logic             frame_eof_r;
  logic             frame_err_r;
  logic [LEN_W-1:0] frame_len_r;

  // Frame delimiter state and registered frame outputs
  always_ff @(posedge rgmii_rx_clk) begin
    if (rst) begin
      state_r       <= IDLE;
      hold_r        <= 8'h00;
      count_r       <= ZERO_LEN;
      sticky_err_r  <= 1'b0;
      frame_data_r  <= 8'h00;
      frame_valid_r <= 1'b0;
      frame_sof_r   <= 1'b0;
      frame_eof_r   <= 1'b0;
      frame_err_r   <= 1'b0;
      frame_len_r   <= ZERO_LEN;
    end else begin
      state_r       <= state_s;
      hold_r        <= hold_s;
      count_r       <= count_s;
      sticky_err_r  <= sticky_err_s;
      frame_data_r  <= fdata_s;
      frame_valid_r <= fvalid_s;
      frame_sof_r   <= fsof_s;
      frame_eof_r   <= feof_s;
      frame_err_r   <= ferr_s;
      frame_len_r   <= flen_s;
    end
  end

  assign frame_data  = frame_data_r;
  assign frame_valid = frame_valid_r;
  assign frame_sof   = frame_sof_r;
  assign frame_eof   = frame_eof_r;
  assign frame_err   = frame_err_r;
  assign frame_len   = frame_len_r;

`ifdef RGMII_RX_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics: bad count covers errored frames and junk bursts that never
  // reached an SFD; an overrun is counted once, via its errored eof.
  // ---------------------------------------------------------------------------
  logic [15:0] stat_frames_r;
  logic [15:0] stat_errors_r;
  logic        good_eof_s;
  logic        bad_event_s;

  assign good_eof_s  = fvalid_s & feof_s & ~ferr_s;
  assign bad_event_s = (fvalid_s & feof_s & ferr_s) | discard_entry_s;

  // Saturating good/bad frame counters
  always_ff @(posedge rgmii_rx_clk) begin
    if (rst) begin
      stat_frames_r <= 16'h0000;
      stat_errors_r <= 16'h0000;
    end else begin
      if (good_eof_s) begin
        stat_frames_r <= sat_inc16(stat_frames_r);
      end else begin
        stat_frames_r <= stat_frames_r;
      end
      if (bad_event_s) begin
        stat_errors_r <= sat_inc16(stat_errors_r);
      end else begin
        stat_errors_r <= stat_errors_r;
      end
    end
  end

  assign stat_frames = stat_frames_r;
  assign stat_errors = stat_errors_r;
`endif

endmodule

// File: tb/tb_rgmii_rx_to_frame.sv
// -----------------------------------------------------------------------------
// tb_rgmii_rx_to_frame
// Scoreboard bench: each transmitted frame is turned into its expected beat
// list (from the frame rules, not the RTL structure) and queued; a monitor on
// the falling edge pops and compares every frame_valid beat. The GMII stream
// is checked against a delayed copy of what was driven. Define
// RGMII_RX_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_rgmii_rx_to_frame;
  import eth_rx_pkg::*;

  localparam int MAXL = 1522;
  localparam int LW   = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    rgmii_rx_data = 4'h0;
  logic          rgmii_rx_ctl  = 1'b0;
  logic [7:0]    gmii_rx_data;
  logic          gmii_rx_dv;
  logic          gmii_rx_er;
  logic [7:0]    frame_data;
  logic          frame_valid;
  logic          frame_sof;
  logic          frame_eof;
  logic          frame_err;
  logic [LW-1:0] frame_len;
`ifdef RGMII_RX_STATS_EN
  logic [15:0]   stat_frames;
  logic [15:0]   stat_errors;
`endif

  always #4 clk = ~clk;

  rgmii_rx_to_frame #(.MAX_FRAME_LEN(MAXL), .LEN_W(LW)) dut (
    .rgmii_rx_clk  (clk),
    .rst           (rst),
    .rgmii_rx_data (rgmii_rx_data),
    .rgmii_rx_ctl  (rgmii_rx_ctl),
    .gmii_rx_data  (gmii_rx_data),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rx_er    (gmii_rx_er),
    .frame_data    (frame_data),
    .frame_valid   (frame_valid),
    .frame_sof     (frame_sof),
    .frame_eof     (frame_eof),
    .frame_err     (frame_err),
    .frame_len     (frame_len)
`ifdef RGMII_RX_STATS_EN
    ,
    .stat_frames   (stat_frames),
    .stat_errors   (stat_errors)
`endif
  );

  typedef struct packed {
    logic [7:0]    data;
    logic          sof;
    logic          eof;
    logic          err;
    logic [LW-1:0] len;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_b;
  int    checks   = 0;
  int    failures = 0;
  bit    mask     = 1'b0;
  int    exp_frames = 0;
  int    exp_errors = 0;

  logic [7:0] pay    [0:1599];
  bit         pay_er [0:1599];

  // Expected GMII pipeline: {er, dv, data} driven for the cycle starting at a rising edge
  logic [9:0] cur = 10'h000;
  logic [9:0] e1 = 10'h000, e2 = 10'h000, e3 = 10'h000;
  bit         v1, v2, v3, rst_q;

  always @(posedge clk) begin
    e1    <= cur;
    e2    <= e1;
    e3    <= e2;
    v1    <= !rst;
    v2    <= v1 && !rst;
    v3    <= v2 && !rst;
    rst_q <= rst;
  end

  // Monitor: reset-zero check, GMII stream check, frame scoreboard
  always @(negedge clk) begin
    if (rst_q) begin
      checks++;
      if ({gmii_rx_data, gmii_rx_dv, gmii_rx_er, frame_data, frame_valid,
           frame_sof, frame_eof, frame_err, frame_len} != '0) begin
        failures++;
        $display("FAIL reset_zero: got gmii=%h/%b/%b frame=%h v=%b sof=%b eof=%b err=%b len=%0d, required all 0",
                 gmii_rx_data, gmii_rx_dv, gmii_rx_er, frame_data, frame_valid,
                 frame_sof, frame_eof, frame_err, frame_len);
      end
`ifdef RGMII_RX_STATS_EN
      checks++;
      if (stat_frames != 16'h0000 || stat_errors != 16'h0000) begin
        failures++;
        $display("FAIL reset_stats: got frames=%0d errors=%0d, required 0/0", stat_frames, stat_errors);
      end
`endif
    end else begin
      if (v3) begin
        checks++;
        if ({gmii_rx_er, gmii_rx_dv, gmii_rx_data} !== e3) begin
          failures++;
          $display("FAIL gmii_stream: got er=%b dv=%b data=%h, required er=%b dv=%b data=%h",
                   gmii_rx_er, gmii_rx_dv, gmii_rx_data, e3[9], e3[8], e3[7:0]);
        end
      end
      if (frame_valid && !mask) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL frame_unexpected: got beat data=%h sof=%b eof=%b, required no beat",
                   frame_data, frame_sof, frame_eof);
        end else begin
          exp_b = exp_q.pop_front();
          if (frame_data !== exp_b.data || frame_sof !== exp_b.sof || frame_eof !== exp_b.eof ||
              (exp_b.eof && (frame_err !== exp_b.err || frame_len !== exp_b.len))) begin
            failures++;
            $display("FAIL frame_beat: got data=%h sof=%b eof=%b err=%b len=%0d, required data=%h sof=%b eof=%b err=%b len=%0d",
                     frame_data, frame_sof, frame_eof, frame_err, frame_len,
                     exp_b.data, exp_b.sof, exp_b.eof, exp_b.err, exp_b.len);
          end
        end
      end
    end
  end

  // One RGMII clock: rising nibble + DV before the rising edge, falling nibble + DV^ER after
  task automatic send_cycle(input logic [7:0] b, input logic dv, input logic er);
    @(negedge clk);
    #1;
    rgmii_rx_data = b[3:0];
    rgmii_rx_ctl  = dv;
    cur           = {er, dv, b};
    @(posedge clk);
    #1;
    rgmii_rx_data = b[7:4];
    rgmii_rx_ctl  = dv ^ er;
  endtask

  // Inter-frame gap with random bus content and occasional false carrier
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      send_cycle(8'($urandom_range(0, 255)), 1'b0, ($urandom_range(0, 7) == 0));
    end
  endtask

  // Queue the expected beats for pay[0:n-1], then transmit preamble, SFD and payload
  task automatic send_frame(input int pre_len, input int n);
    int    m;
    bit    any_er;
    beat_t b;
    m      = (n > MAXL) ? MAXL : n;
    any_er = 1'b0;
    for (int i = 0; i < m; i++) begin
      any_er |= pay_er[i];
    end
    for (int i = 0; i < m; i++) begin
      b.data = pay[i];
      b.sof  = (i == 0);
      b.eof  = (i == m - 1);
      b.err  = b.eof ? ((n > MAXL) ? 1'b1 : any_er) : 1'b0;
      b.len  = b.eof ? LW'(m) : '0;
      exp_q.push_back(b);
    end
    if (m > 0) begin
      if ((n > MAXL) || any_er) exp_errors++;
      else exp_frames++;
    end
    for (int i = 0; i < pre_len; i++) send_cycle(PREAMBLE_BYTE, 1'b1, 1'b0);
    send_cycle(SFD_BYTE, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) send_cycle(pay[i], 1'b1, pay_er[i]);
  endtask

  task automatic clear_er();
    for (int i = 0; i < 1600; i++) pay_er[i] = 1'b0;
  endtask

  task automatic check_stats(input string name);
`ifdef RGMII_RX_STATS_EN
    checks++;
    if (stat_frames != 16'(exp_frames) || stat_errors != 16'(exp_errors)) begin
      failures++;
      $display("FAIL stats_%s: got frames=%0d errors=%0d, required frames=%0d errors=%0d",
               name, stat_frames, stat_errors, exp_frames, exp_errors);
    end
`endif
  endtask

  initial begin
    logic [7:0] jb;
    clear_er();
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(8);
    check_stats("after_reset");

    // Basic 64-byte frame
    for (int i = 0; i < 64; i++) pay[i] = 8'(i);
    send_frame(7, 64);
    idle(8);
    check_stats("good64");

    // Same frame with er on byte 10
    pay_er[10] = 1'b1;
    send_frame(7, 64);
    clear_er();
    idle(8);
    check_stats("er64");

    // Preamble then junk byte -> discard, nothing emitted
    send_cycle(8'h55, 1'b1, 1'b0);
    send_cycle(8'h55, 1'b1, 1'b0);
    send_cycle(8'h12, 1'b1, 1'b0);
    exp_errors++;
    idle(8);
    check_stats("discard");

    // Preamble aborted and SFD-only frame: no output, no stats
    send_cycle(8'h55, 1'b1, 1'b0);
    send_cycle(8'h55, 1'b1, 1'b0);
    idle(3);
    send_frame(7, 0);
    idle(6);
    check_stats("aborts");

    // Overrun: MAXL+5 bytes
    for (int i = 0; i < MAXL + 5; i++) pay[i] = 8'($urandom_range(0, 255));
    send_frame(7, MAXL + 5);
    idle(8);
    check_stats("overrun");

    // Exactly MAXL bytes is a normal frame
    send_frame(3, MAXL);
    idle(8);
    check_stats("maxlen");

    // Single-byte frame, zero-length preamble
    pay[0] = 8'hAB;
    send_frame(0, 1);
    idle(8);
    check_stats("single");

    // Reset during byte 20 of a 60-byte frame
    mask = 1'b1;
    for (int i = 0; i < 7; i++) send_cycle(PREAMBLE_BYTE, 1'b1, 1'b0);
    send_cycle(SFD_BYTE, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) send_cycle(8'(i), 1'b1, 1'b0);
    rst = 1'b1;
    send_cycle(8'd20, 1'b1, 1'b0);
    send_cycle(8'd21, 1'b1, 1'b0);
    rst  = 1'b0;
    mask = 1'b0;
    exp_frames = 0;
    exp_errors = 1;   // tail of the frame hits IDLE with a non-preamble byte
    for (int i = 22; i < 60; i++) send_cycle(8'(i), 1'b1, 1'b0);
    idle(8);
    check_stats("reset_mid");
    for (int i = 0; i < 64; i++) pay[i] = 8'(8'hC0 ^ 8'(i));
    send_frame(7, 64);
    idle(8);
    check_stats("after_reset_mid");

    // Randomized traffic
    for (int f = 0; f < 40; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        jb = 8'($urandom_range(0, 255));
        while (jb == PREAMBLE_BYTE || jb == SFD_BYTE) jb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) send_cycle(PREAMBLE_BYTE, 1'b1, 1'b0);
        send_cycle(jb, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_cycle(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        exp_errors++;
      end else if (kind == 1) begin
        for (int i = 0; i < 4; i++) send_cycle(PREAMBLE_BYTE, 1'b1, 1'b0);
      end else begin
        int n;
        n = $urandom_range(1, 80);
        for (int i = 0; i < n; i++) begin
          pay[i]    = 8'($urandom_range(0, 255));
          pay_er[i] = ($urandom_range(0, 39) == 0);
        end
        send_frame($urandom_range(0, 7), n);
        clear_er();
      end
      idle($urandom_range(1, 6));
    end
    idle(12);
    check_stats("random");

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d beats still expected, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
